nina_boot_sequencer: RTL

Generates the NINA (ESP32) EN/reset and GPIO0 boot-strap waveforms for the FPGA-to-NINA programming path. It replaces direct button-to-pin wiring with synchronised, debounced button inputs plus register-driven requests. A fixed-timing state machine puts the module into run mode or serial-download mode. Outputs drive the NINA reset and strap pins directly; status feeds the system register space.

---
 rtl/nina_boot_sequencer_if.sv | 28 ++
 rtl/nina_boot_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/nina_boot_sequencer_if.sv
// Request/status bundle between the system register block and the NINA boot sequencer.
// The master issues requests; the slave (sequencer) drives the pin and status outputs.
interface nina_boot_sequencer_if;
  logic iPROG_REQ;
  logic iRUN_REQ;
  logic oWM_EN;
  logic oWM_BOOT;
  logic oBUSY;
  logic oMODE;

  modport master (
    output iPROG_REQ,
    output iRUN_REQ,
    input  oWM_EN,
    input  oWM_BOOT,
    input  oBUSY,
    input  oMODE
  );

  modport slave (
    input  iPROG_REQ,
    input  iRUN_REQ,
    output oWM_EN,
    output oWM_BOOT,
    output oBUSY,
    output oMODE
  );
endinterface

// File: rtl/nina_boot_sequencer.sv
// Drives the NINA (ESP32) EN and GPIO0 strap pins through a fixed-timing run or download sequence,
// started by debounced buttons or register requests; a run sequence also follows every reset.
module nina_boot_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 480000,
  parameter int unsigned RESET_HOLD_CYCLES = 4800000,
  parameter int unsigned BOOT_HOLD_CYCLES  = 2400000,
  parameter int unsigned CNT_W             = 24
) (
  input  logic                 iCLK,
  input  logic                 iRESETn,
  input  logic                 iRESET_BTN,
  input  logic                 iBOOT_BTN,
  nina_boot_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_STRAP  = 2'd1,
    ST_IDLE   = 2'd2
  } state_t;

  // Bit 0 is the reset button, bit 1 the boot button; 1 means released.
  logic [1:0]            sync1_q;
  logic [1:0]            sync2_q;
  logic [1:0]            deb_q;
  logic [1:0][CNT_W-1:0] deb_cnt_q;
  logic                  deb_prev_q;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  mode_q;
  logic                  wm_en_q;
  logic                  wm_boot_q;
  logic                  busy_q;
  logic                  mode_out_q;

  logic                  press_s;
  logic                  start_d;
  logic                  start_mode_d;

  // Two-flop synchronisers for the asynchronous button pins.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {iBOOT_BTN, iRESET_BTN};
      sync2_q <= sync1_q;
    end
  end

  // Debouncers: a change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      deb_q      <= 2'b11;
      deb_cnt_q  <= {(2*CNT_W){1'b0}};
      deb_prev_q <= 1'b1;
    end else begin
      deb_prev_q <= deb_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= {CNT_W{1'b0}};
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= {CNT_W{1'b0}};
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Start decode; download has priority when both conditions are present.
  always_comb begin
    press_s      = deb_prev_q & ~deb_q[0];
    start_d      = 1'b0;
    start_mode_d = 1'b0;
    if (bus.iPROG_REQ || (press_s && !deb_q[1])) begin
      start_d      = 1'b1;
      start_mode_d = 1'b1;
    end else if (bus.iRUN_REQ || press_s) begin
      start_d      = 1'b1;
      start_mode_d = 1'b0;
    end else begin
      start_d      = 1'b0;
      start_mode_d = 1'b0;
    end
  end

  // Sequence FSM with registered pin and status outputs; starts are ignored outside IDLE.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= {CNT_W{1'b0}};
      mode_q     <= 1'b0;
      wm_en_q    <= 1'b0;
      wm_boot_q  <= 1'b1;
      busy_q     <= 1'b1;
      mode_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            state_q   <= ST_ASSERT;
            mode_q    <= start_mode_d;
            cnt_q     <= {CNT_W{1'b0}};
            wm_en_q   <= 1'b0;
            wm_boot_q <= ~start_mode_d;
            busy_q    <= 1'b1;
          end else begin
            wm_en_q   <= 1'b1;
            wm_boot_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (cnt_q == RESET_LAST) begin
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= ST_STRAP;
            wm_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_STRAP: begin
          if (cnt_q == BOOT_LAST) begin
            cnt_q      <= {CNT_W{1'b0}};
            state_q    <= ST_IDLE;
            wm_boot_q  <= 1'b1;
            busy_q     <= 1'b0;
            mode_out_q <= mode_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= ST_ASSERT;
          cnt_q     <= {CNT_W{1'b0}};
          mode_q    <= 1'b0;
          wm_en_q   <= 1'b0;
          wm_boot_q <= 1'b1;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.oWM_EN   = wm_en_q;
  assign bus.oWM_BOOT = wm_boot_q;
  assign bus.oBUSY    = busy_q;
  assign bus.oMODE    = mode_out_q;

endmodule
